chacha_ctrl: RTL and testbench

CHACHA_CTRL -- requirements
Module: chacha_ctrl

---
 rtl/chacha_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_chacha_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_ctrl.sv
// chacha_ctrl: sequencing controller between a host and a ChaCha core.
// The host issues commands to load the key (32 bytes), nonce (12 bytes)
// or block counter (4 bytes), or to generate a block. Load bytes are
// forwarded to the core with a per-field write strobe. A generate command
// streams the core's 64-byte block to the host under ready/valid
// handshaking. A generate command without key and nonce loaded is rejected
// with a one-cycle err pulse.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_op/cmd_ready  command handshake (00 key, 01 nonce,
//                               10 counter, 11 generate)
//   din/din_valid/din_ready     host load byte handshake
//   dout/dout_valid/dout_ready  keystream byte handshake
//   dout_last                   marks byte 63 of a block
//   err                         one-cycle pulse on a rejected generate
//   blk_count                   completed block count, wraps at 255
//   core_wr_key/nnc/ctr         core load strobes
//   core_data_in                byte bus to core, 0 when idle
//   core_blk_ready              core has a block available
//   core_rd_blk                 core read-advance strobe
//   core_data_out               current core block byte
module chacha_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last,
  output logic       err,
  output logic [7:0] blk_count,
  output logic       core_wr_key,
  output logic       core_wr_nnc,
  output logic       core_wr_ctr,
  output logic [7:0] core_data_in,
  input  logic       core_blk_ready,
  output logic       core_rd_blk,
  input  logic [7:0] core_data_out
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BLK, STREAM} state_t;

  localparam logic [1:0] OP_KEY = 2'b00;
  localparam logic [1:0] OP_NNC = 2'b01;
  localparam logic [1:0] OP_CTR = 2'b10;
  localparam logic [1:0] OP_GEN = 2'b11;

  state_t     state, state_next;
  logic [1:0] op, op_next;
  logic [5:0] cnt, cnt_next;
  logic       key_ok, key_ok_next;
  logic       nnc_ok, nnc_ok_next;
  logic       ctr_ok, ctr_ok_next;
  logic       err_q, err_next;
  logic [7:0] blk_q, blk_next;
  logic [5:0] last_idx;

  // Index of the final byte of the load selected by the latched op.
  always_comb begin
    case (op)
      OP_KEY:  last_idx = 6'd31;
      OP_NNC:  last_idx = 6'd11;
      default: last_idx = 6'd3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      op     <= OP_KEY;
      cnt    <= '0;
      key_ok <= 1'b0;
      nnc_ok <= 1'b0;
      ctr_ok <= 1'b0;
      err_q  <= 1'b0;
      blk_q  <= '0;
    end else begin
      state  <= state_next;
      op     <= op_next;
      cnt    <= cnt_next;
      key_ok <= key_ok_next;
      nnc_ok <= nnc_ok_next;
      ctr_ok <= ctr_ok_next;
      err_q  <= err_next;
      blk_q  <= blk_next;
    end
  end

  always_comb begin
    state_next   = state;
    op_next      = op;
    cnt_next     = cnt;
    key_ok_next  = key_ok;
    nnc_ok_next  = nnc_ok;
    ctr_ok_next  = ctr_ok;
    err_next     = 1'b0;
    blk_next     = blk_q;
    cmd_ready    = 1'b0;
    din_ready    = 1'b0;
    dout         = '0;
    dout_valid   = 1'b0;
    dout_last    = 1'b0;
    core_wr_key  = 1'b0;
    core_wr_nnc  = 1'b0;
    core_wr_ctr  = 1'b0;
    core_data_in = '0;
    core_rd_blk  = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op != OP_GEN) begin
            op_next    = cmd_op;
            cnt_next   = '0;
            state_next = LOAD;
          end else if (key_ok && nnc_ok) begin
            state_next = WAIT_BLK;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      LOAD: begin
        din_ready = 1'b1;
        if (din_valid) begin
          core_data_in = din;
          core_wr_key  = (op == OP_KEY);
          core_wr_nnc  = (op == OP_NNC);
          core_wr_ctr  = (op == OP_CTR);
          cnt_next     = cnt + 6'd1;
          if (cnt == last_idx) begin
            state_next = IDLE;
            case (op)
              OP_KEY:  key_ok_next = 1'b1;
              OP_NNC:  nnc_ok_next = 1'b1;
              default: ctr_ok_next = 1'b1;
            endcase
          end
        end
      end

      WAIT_BLK: begin
        if (core_blk_ready) begin
          cnt_next   = '0;
          state_next = STREAM;
        end
      end

      STREAM: begin
        dout_valid  = 1'b1;
        dout        = core_data_out;
        dout_last   = (cnt == 6'd63);
        core_rd_blk = dout_ready;
        if (dout_ready) begin
          cnt_next = cnt + 6'd1;
          if (cnt == 6'd63) begin
            blk_next   = blk_q + 8'd1;
            state_next = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase

    // While reset is held, the state may not yet be IDLE, so every
    // combinational output is forced quiet here.
    if (!rst_n) begin
      cmd_ready    = 1'b0;
      din_ready    = 1'b0;
      dout         = '0;
      dout_valid   = 1'b0;
      dout_last    = 1'b0;
      core_wr_key  = 1'b0;
      core_wr_nnc  = 1'b0;
      core_wr_ctr  = 1'b0;
      core_data_in = '0;
      core_rd_blk  = 1'b0;
    end
  end

  // The registered outputs are also masked during reset so that they read 0
  // even before the first reset edge has cleared them.
  assign err       = rst_n & err_q;
  assign blk_count = rst_n ? blk_q : 8'd0;

endmodule

// File: tb/tb_chacha_ctrl.sv
// tb_chacha_ctrl: directed self-checking bench for chacha_ctrl.
// A small core stand-in presents byte (read index ^ 0x5A) and advances on
// core_rd_blk, so skipped or repeated stream bytes show up as data errors.
module tb_chacha_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       dout_last;
  logic       err;
  logic [7:0] blk_count;
  logic       core_wr_key, core_wr_nnc, core_wr_ctr;
  logic [7:0] core_data_in;
  logic       core_blk_ready;
  logic       core_rd_blk;
  logic [7:0] core_data_out;

  int vectors = 0;
  int miscompares = 0;
  int strobe_cnt;
  int nxfer;
  logic [7:0] g = 8'd0;
  logic [7:0] rd_idx = 8'd0;
  logic [7:0] dbyte;
  logic       v;

  chacha_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .err(err), .blk_count(blk_count),
    .core_wr_key(core_wr_key), .core_wr_nnc(core_wr_nnc),
    .core_wr_ctr(core_wr_ctr), .core_data_in(core_data_in),
    .core_blk_ready(core_blk_ready), .core_rd_blk(core_rd_blk),
    .core_data_out(core_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_rd_blk) rd_idx <= rd_idx + 8'd1;
  assign core_data_out = rd_idx ^ 8'h5A;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic cv, input logic [1:0] op,
                               input logic dv, input logic [7:0] d,
                               input logic dr, input logic br);
    cmd_valid      = cv;
    cmd_op         = op;
    din_valid      = dv;
    din            = d;
    dout_ready     = dr;
    core_blk_ready = br;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: bench did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, with a command offered that must not be acknowledged.
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'b11, 1'b1, 8'hFF, 1'b1, 1'b1);
    tick;
    tick;
    applyStimulus(1'b1, 2'b11, 1'b1, 8'hFF, 1'b1, 1'b1);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 0);
    checkOutput("rst_din_ready", 32'(din_ready), 0);
    checkOutput("rst_dout_valid", 32'(dout_valid), 0);
    checkOutput("rst_dout_last", 32'(dout_last), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_blk_count", 32'(blk_count), 0);
    checkOutput("rst_strobes", 32'({core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk}), 0);
    checkOutput("rst_core_data_in", 32'(core_data_in), 0);

    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("cmd_ready_after_reset", 32'(cmd_ready), 1);

    // Generate with nothing loaded: one-cycle err, stays IDLE.
    applyStimulus(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("gen_noload_strobes", 32'({core_wr_key, core_wr_nnc, core_wr_ctr, core_rd_blk}), 0);
    tick;
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("gen_noload_err", 32'(err), 1);
    checkOutput("gen_noload_idle", 32'(cmd_ready), 1);
    tick;
    checkOutput("gen_noload_err_gone", 32'(err), 0);

    // Key load 0x00..0x1F, din_valid continuous; a stray command mid-load.
    applyStimulus(1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    tick;
    strobe_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(i == 5, 2'b11, 1'b1, 8'(i), 1'b0, 1'b0);
      checkOutput("key_din_ready", 32'(din_ready), 1);
      checkOutput("key_core_data_in", 32'(core_data_in), 32'(i));
      checkOutput("key_other_strobes", 32'({core_wr_nnc, core_wr_ctr}), 0);
      if (i == 5) checkOutput("key_cmd_ignored", 32'(cmd_ready), 0);
      strobe_cnt += int'(core_wr_key);
      tick;
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("key_back_idle", 32'(cmd_ready), 1);
    checkOutput("key_strobe_off", 32'(core_wr_key), 0);
    checkOutput("key_strobe_cycles", 32'(strobe_cnt), 32);

    // Nonce load with din_valid toggling every other cycle.
    applyStimulus(1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    tick;
    strobe_cnt = 0;
    nxfer = 0;
    for (int c = 0; c < 23; c++) begin
      v = (c % 2 == 0);
      dbyte = 8'(8'h40 + nxfer);
      applyStimulus(1'b0, 2'b00, v, dbyte, 1'b0, 1'b0);
      checkOutput("nnc_strobe", 32'(core_wr_nnc), 32'(v));
      checkOutput("nnc_core_data_in", 32'(core_data_in), v ? 32'(dbyte) : 0);
      strobe_cnt += int'(core_wr_nnc);
      if (v) nxfer++;
      tick;
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("nnc_back_idle", 32'(cmd_ready), 1);
    checkOutput("nnc_transfers", 32'(strobe_cnt), 12);

    // Counter load, 4 bytes.
    applyStimulus(1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0);
    tick;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'b00, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      checkOutput("ctr_strobe", 32'({core_wr_key, core_wr_nnc, core_wr_ctr}), 1);
      tick;
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("ctr_back_idle", 32'(cmd_ready), 1);

    // Generate; the core reports its block several cycles later.
    applyStimulus(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0);
    tick;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("wait_no_err", 32'(err), 0);
      checkOutput("wait_cmd_ready", 32'(cmd_ready), 0);
      checkOutput("wait_dout_valid", 32'(dout_valid), 0);
      checkOutput("wait_rd_blk", 32'(core_rd_blk), 0);
      tick;
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("blk_ready_cycle_valid", 32'(dout_valid), 0);
    tick;

    // Stream 64 bytes, stalling 3 cycles in front of byte 10.
    for (int b = 0; b < 64; b++) begin
      if (b == 10) begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
          checkOutput("stall_rd_blk", 32'(core_rd_blk), 0);
          checkOutput("stall_dout", 32'(dout), 32'(g ^ 8'h5A));
          checkOutput("stall_dout_valid", 32'(dout_valid), 1);
          tick;
        end
      end
      applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("stream_dout_valid", 32'(dout_valid), 1);
      checkOutput("stream_dout", 32'(dout), 32'(g ^ 8'h5A));
      checkOutput("stream_dout_last", 32'(dout_last), 32'(b == 63));
      checkOutput("stream_rd_blk", 32'(core_rd_blk), 1);
      tick;
      g = g + 8'd1;
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("post_block_valid", 32'(dout_valid), 0);
    checkOutput("post_block_count", 32'(blk_count), 1);
    checkOutput("post_block_idle", 32'(cmd_ready), 1);

    // Second generate, reset asserted at stream byte 20.
    applyStimulus(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
    tick;
    for (int b = 0; b < 20; b++) begin
      applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1);
      checkOutput("blk2_dout", 32'(dout), 32'(g ^ 8'h5A));
      tick;
      g = g + 8'd1;
    end
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("midrst_rd_blk", 32'(core_rd_blk), 0);
    tick;
    rst_n = 1'b1;
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("midrst_dout_valid", 32'(dout_valid), 0);
    checkOutput("midrst_blk_count", 32'(blk_count), 0);
    checkOutput("midrst_idle", 32'(cmd_ready), 1);
    applyStimulus(1'b1, 2'b11, 1'b0, 8'h00, 1'b0, 1'b0);
    tick;
    applyStimulus(1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("midrst_gen_err", 32'(err), 1);
    tick;
    checkOutput("midrst_gen_err_gone", 32'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
